frame_buf_sched: RTL and testbench
==================================

# frame_buf_sched

Slot scheduler for the triple-buffered video frame store. It owns the per-slot state table, gives the DDR writer a free slot base address for each incoming frame, and gives the DDR reader the newest completed frame. It drops stale frames when the writer outruns the reader and repeats the last frame when the reader outruns the writer. It sits between the frame writer/reader engines and the shared AXI4 memory, on the single system clock.

## Interface
- START_ADDR, 32'h3fff0000, byte address of slot 0
- FRAMES_AMOUNT, 3, number of slots; legal range 3..8
- FRAME_RES_X, 1920, active pixels per line
- FRAME_RES_Y, 1080, active lines per frame
- PX_BYTES, 2, bytes per pixel in memory
- ADDR_WIDTH, 32, address width
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous and active-high
- wr_req_i  in  1  writer asks for a slot; level, held until wr_ack_o
- wr_ack_o  out  1  one-cycle grant pulse to the writer
- wr_addr_o  out  ADDR_WIDTH  base address of the granted write slot
- wr_done_stb_i  in  1  one-cycle pulse: the current write slot is complete
- rd_req_i  in  1  reader asks for a frame; level, held until rd_ack_o
- rd_ack_o  out  1  one-cycle grant pulse to the reader
- rd_addr_o  out  ADDR_WIDTH  base address of the granted read slot
- rd_repeat_o  out  1  valid with rd_ack_o; 1 = grant is a re-read of the previous frame
- rd_done_stb_i  in  1  one-cycle pulse: the reader has finished its slot
- drop_cnt_o  out  16  frames overwritten unread (only with FRAME_BUF_SCHED_STATS_EN)
- repeat_cnt_o  out  16  repeated grants (only with FRAME_BUF_SCHED_STATS_EN)

## Operation
- Slot pitch: FRAME_BYTES = RES_X*RES_Y*PX_BYTES, rounded up to a multiple of 4096.
  - Defaults give 0x3F5000.
  - slot k address = START_ADDR + k*FRAME_BYTES, computed modulo 2^ADDR_WIDTH.
- Slot states: FREE, WRITING, READY, SHOWN, READING.
  - At most one slot each is WRITING, READY, and SHOWN-or-READING.
- Write grant:
  - Picks the lowest-index FREE slot and moves it to WRITING.
  - If a WRITING slot already exists (aborted frame), that slot becomes FREE first.
- wr_done_stb_i:
  - The WRITING slot moves to READY.
  - Any older READY slot moves to FREE, and the drop counter increments.
  - The strobe is ignored if no slot is WRITING.
- Read grant, evaluated in this order:
  - If a READY slot exists: it moves to READING, any SHOWN slot moves to FREE, rd_repeat_o=0.
  - Else if a SHOWN slot exists: it moves to READING, rd_repeat_o=1, and the repeat counter increments.
  - Else: no grant; the request stays pending.
- rd_done_stb_i: READING moves to SHOWN. The strobe is ignored if no slot is READING.
- rd_req_i while a slot is READING: that slot is treated as SHOWN before evaluation.
- Arbiter FSM: IDLE -> ARB -> GRANT -> IDLE.
  - IDLE: move to ARB when any request is pending.
  - ARB: choose the requester and update the table.
  - GRANT: drive the ack pulse.
  - If both requesters are pending, selection is round-robin; the writer wins first after reset.
  - A pending read with no grantable slot is skipped; the arbiter returns to IDLE and retries.
- Done strobes are applied in every FSM state. A strobe arriving in the ARB cycle is applied before that cycle's decision.
- With 3 or more slots, a write grant always finds a FREE slot.

## Timing
- Request first sampled high at edge N: ack is high during cycle N+2.
- wr_addr_o / rd_addr_o / rd_repeat_o update together with the ack and hold until the next grant of the same side.
- Ack is a single-cycle pulse. The requester deasserts its request in the cycle after the ack.
- Simultaneous wr_done_stb_i and a read decision in ARB: the reader receives the just-completed frame.
- Reset values:
  - Outputs: acks 0, addresses START_ADDR, rd_repeat_o 0, counters 0.
  - Internal: all slots FREE, FSM IDLE.
- Reset mid-operation discards all slot state within one cycle. No ack is issued in the cycle rst_i is high.
- Counters saturate at 16'hFFFF.

## Configuration
- FRAME_BUF_SCHED_STATS_EN defined: drop_cnt_o and repeat_cnt_o ports and their counters exist.
- Undefined: the ports are absent, and no counter logic is built.
- All slot scheduling behaviour is identical either way.

## Test plan
- Reset, then wr_req_i: ack at N+2, wr_addr_o=0x3FFF0000. Second write cycle: wr_addr_o=0x403E5000.
- Write slot0, wr_done, then rd_req_i: rd_addr_o=0x3FFF0000, rd_repeat_o=0. Next write is granted 0x403E5000.
- Reader fast:
  - Complete one write, read it, rd_done, rd_req again with no new write.
  - Required: same address, rd_repeat_o=1, repeat_cnt_o=1.
- Writer fast:
  - Complete 3 writes while the reader holds slot0.
  - Required: each new READY frees the old one, drop_cnt_o=2, and the next read gets the newest slot.
- Both requests high in the same cycle after reset: writer acked first; reader acked 3 cycles later. wr_done in the reader's ARB cycle gives that frame to the reader.
- rd_req_i before any write completes: no rd_ack_o. Assert rst_i mid-write: all slots FREE, and the next write is granted 0x3FFF0000.

Source files
------------

// File: rtl/frame_buf_sched.sv
// frame_buf_sched: slot scheduler for the triple-buffered video frame store.
// Hands the DDR writer a free slot per incoming frame and hands the DDR reader
// the newest completed frame. Stale frames are dropped and the last frame is
// repeated when the two sides run at different rates.
// Optional macro FRAME_BUF_SCHED_STATS_EN adds the drop/repeat counter ports.
module frame_buf_sched #(
    parameter int unsigned           ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR    = 32'h3fff0000,
    parameter int unsigned           FRAMES_AMOUNT = 3,
    parameter int unsigned           FRAME_RES_X   = 1920,
    parameter int unsigned           FRAME_RES_Y   = 1080,
    parameter int unsigned           PX_BYTES      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_req_i,
    output logic                  wr_ack_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    input  logic                  wr_done_stb_i,
    input  logic                  rd_req_i,
    output logic                  rd_ack_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  rd_repeat_o,
    input  logic                  rd_done_stb_i
`ifdef FRAME_BUF_SCHED_STATS_EN
    ,
    output logic [15:0]           drop_cnt_o,
    output logic [15:0]           repeat_cnt_o
`endif
);

    // Per-slot states
    localparam logic [2:0] S_FREE    = 3'd0;
    localparam logic [2:0] S_WRITING = 3'd1;
    localparam logic [2:0] S_READY   = 3'd2;
    localparam logic [2:0] S_SHOWN   = 3'd3;
    localparam logic [2:0] S_READING = 3'd4;

    // Arbiter states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    // Slot pitch rounded up to a 4 KiB boundary
    localparam logic [63:0] FRAME_BYTES =
        ((64'(FRAME_RES_X) * 64'(FRAME_RES_Y) * 64'(PX_BYTES) + 64'd4095) / 64'd4096) * 64'd4096;

    function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [2:0] idx);
        logic [63:0] a;
        a = 64'(START_ADDR) + 64'(idx) * FRAME_BYTES;
        return a[ADDR_WIDTH-1:0];
    endfunction

    logic [1:0]            r_state;
    logic [2:0]            r_slot     [FRAMES_AMOUNT];
    logic                  r_wr_ack;
    logic                  r_rd_ack;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rd_repeat;
    logic                  r_prio_rd;

    logic [2:0]            w_tbl_done [FRAMES_AMOUNT];
    logic [2:0]            w_tbl_next [FRAMES_AMOUNT];
    logic                  w_has_writing;
    logic                  w_ready_any;
    logic [2:0]            w_ready_idx;
    logic                  w_shown_any;
    logic [2:0]            w_shown_idx;
    logic                  w_free_any;
    logic [2:0]            w_free_idx;
    logic                  w_rd_ok;
    logic                  w_wr_sel;
    logic                  w_rd_sel;
    logic                  w_rd_repeat;
    logic [2:0]            w_rd_idx;
`ifdef FRAME_BUF_SCHED_STATS_EN
    logic                  w_drop;
`endif

    // Apply done strobes first, then arbitrate on the updated table.
    // A READING slot counts as SHOWN for read evaluation, so a re-request
    // while reading either repeats it or releases it for a newer frame.
    always_comb begin
        w_has_writing = 1'b0;
`ifdef FRAME_BUF_SCHED_STATS_EN
        w_drop        = 1'b0;
`endif
        for (int unsigned k = 0; k < FRAMES_AMOUNT; k++) begin
            w_tbl_done[k] = r_slot[k];
            if (r_slot[k] == S_WRITING) w_has_writing = 1'b1;
        end
        for (int unsigned k = 0; k < FRAMES_AMOUNT; k++) begin
            if (wr_done_stb_i && w_has_writing) begin
                if (r_slot[k] == S_WRITING) begin
                    w_tbl_done[k] = S_READY;
                end else if (r_slot[k] == S_READY) begin
                    w_tbl_done[k] = S_FREE;
`ifdef FRAME_BUF_SCHED_STATS_EN
                    w_drop        = 1'b1;
`endif
                end
            end
            if (rd_done_stb_i && r_slot[k] == S_READING) w_tbl_done[k] = S_SHOWN;
        end

        w_ready_any = 1'b0;
        w_ready_idx = '0;
        w_shown_any = 1'b0;
        w_shown_idx = '0;
        w_free_any  = 1'b0;
        w_free_idx  = '0;
        for (int unsigned k = 0; k < FRAMES_AMOUNT; k++) begin
            if (w_tbl_done[k] == S_READY) begin
                w_ready_any = 1'b1;
                w_ready_idx = 3'(k);
            end
            if (w_tbl_done[k] == S_SHOWN || w_tbl_done[k] == S_READING) begin
                w_shown_any = 1'b1;
                w_shown_idx = 3'(k);
            end
            if (!w_free_any && (w_tbl_done[k] == S_FREE || w_tbl_done[k] == S_WRITING)) begin
                w_free_any = 1'b1;
                w_free_idx = 3'(k);
            end
        end

        w_rd_ok     = rd_req_i && (w_ready_any || w_shown_any);
        w_wr_sel    = (r_state == ST_ARB) && wr_req_i && (!w_rd_ok || !r_prio_rd);
        w_rd_sel    = (r_state == ST_ARB) && w_rd_ok && !w_wr_sel;
        w_rd_repeat = !w_ready_any;
        w_rd_idx    = w_ready_any ? w_ready_idx : w_shown_idx;

        for (int unsigned k = 0; k < FRAMES_AMOUNT; k++) begin
            w_tbl_next[k] = w_tbl_done[k];
            if (w_wr_sel) begin
                if (w_tbl_done[k] == S_WRITING) w_tbl_next[k] = S_FREE;
                if (3'(k) == w_free_idx)        w_tbl_next[k] = S_WRITING;
            end else if (w_rd_sel) begin
                if (w_ready_any) begin
                    if (w_tbl_done[k] == S_READY)
                        w_tbl_next[k] = S_READING;
                    else if (w_tbl_done[k] == S_SHOWN || w_tbl_done[k] == S_READING)
                        w_tbl_next[k] = S_FREE;
                end else if (3'(k) == w_shown_idx) begin
                    w_tbl_next[k] = S_READING;
                end
            end
        end
    end

    // Slot table, arbiter FSM, grant outputs and round-robin priority
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            for (int unsigned k = 0; k < FRAMES_AMOUNT; k++) r_slot[k] <= S_FREE;
            r_wr_ack    <= 1'b0;
            r_rd_ack    <= 1'b0;
            r_wr_addr   <= START_ADDR;
            r_rd_addr   <= START_ADDR;
            r_rd_repeat <= 1'b0;
            r_prio_rd   <= 1'b0;
        end else begin
            r_slot   <= w_tbl_next;
            r_wr_ack <= w_wr_sel;
            r_rd_ack <= w_rd_sel;
            if (w_wr_sel) begin
                r_wr_addr <= slot_addr(w_free_idx);
                r_prio_rd <= 1'b1;
            end
            if (w_rd_sel) begin
                r_rd_addr   <= slot_addr(w_rd_idx);
                r_rd_repeat <= w_rd_repeat;
                r_prio_rd   <= 1'b0;
            end
            case (r_state)
                ST_IDLE:  if (wr_req_i || rd_req_i) r_state <= ST_ARB;
                ST_ARB:   r_state <= (w_wr_sel || w_rd_sel) ? ST_GRANT : ST_IDLE;
                ST_GRANT: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FRAME_BUF_SCHED_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [15:0] r_repeat_cnt;

    // Saturating statistics counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drop_cnt   <= '0;
            r_repeat_cnt <= '0;
        end else begin
            if (w_drop && r_drop_cnt != 16'hFFFF)                  r_drop_cnt   <= r_drop_cnt + 16'd1;
            if (w_rd_sel && w_rd_repeat && r_repeat_cnt != 16'hFFFF) r_repeat_cnt <= r_repeat_cnt + 16'd1;
        end
    end

    assign drop_cnt_o   = r_drop_cnt;
    assign repeat_cnt_o = r_repeat_cnt;
`endif

    // Acks are masked while reset is asserted
    assign wr_ack_o    = r_wr_ack && !rst_i;
    assign rd_ack_o    = r_rd_ack && !rst_i;
    assign wr_addr_o   = r_wr_addr;
    assign rd_addr_o   = r_rd_addr;
    assign rd_repeat_o = r_rd_repeat;

endmodule

// File: tb/tb_frame_buf_sched.sv
// tb_frame_buf_sched: scoreboard bench for frame_buf_sched (default parameters).
// Expected grants are queued when a request is issued and checked on each ack.
module tb_frame_buf_sched;

    localparam logic [31:0] START = 32'h3fff0000;
    localparam logic [31:0] PITCH = 32'h003F5000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wr_req_i = 1'b0;
    logic        wr_ack_o;
    logic [31:0] wr_addr_o;
    logic        wr_done_stb_i = 1'b0;
    logic        rd_req_i = 1'b0;
    logic        rd_ack_o;
    logic [31:0] rd_addr_o;
    logic        rd_repeat_o;
    logic        rd_done_stb_i = 1'b0;
`ifdef FRAME_BUF_SCHED_STATS_EN
    logic [15:0] drop_cnt_o;
    logic [15:0] repeat_cnt_o;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        rep;
    } rd_exp_t;

    logic [31:0] wr_exp_q [$];
    rd_exp_t     rd_exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] a0, a1, a2;

    always #5 clk_i = ~clk_i;

    frame_buf_sched #(
        .ADDR_WIDTH    (32),
        .START_ADDR    (START),
        .FRAMES_AMOUNT (3),
        .FRAME_RES_X   (1920),
        .FRAME_RES_Y   (1080),
        .PX_BYTES      (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wr_req_i      (wr_req_i),
        .wr_ack_o      (wr_ack_o),
        .wr_addr_o     (wr_addr_o),
        .wr_done_stb_i (wr_done_stb_i),
        .rd_req_i      (rd_req_i),
        .rd_ack_o      (rd_ack_o),
        .rd_addr_o     (rd_addr_o),
        .rd_repeat_o   (rd_repeat_o),
        .rd_done_stb_i (rd_done_stb_i)
`ifdef FRAME_BUF_SCHED_STATS_EN
        ,
        .drop_cnt_o    (drop_cnt_o),
        .repeat_cnt_o  (repeat_cnt_o)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Scoreboard: every ack pops and checks one expected grant
    always @(negedge clk_i) begin
        if (wr_ack_o) begin
            if (wr_exp_q.size() == 0) check_val("wr_ack_unexpected", 64'(wr_ack_o), 64'd0);
            else check_val("wr_addr", 64'(wr_addr_o), 64'(wr_exp_q.pop_front()));
        end
        if (rd_ack_o) begin
            if (rd_exp_q.size() == 0) begin
                check_val("rd_ack_unexpected", 64'(rd_ack_o), 64'd0);
            end else begin
                rd_exp_t e;
                e = rd_exp_q.pop_front();
                check_val("rd_addr", 64'(rd_addr_o), 64'(e.addr));
                check_val("rd_repeat", 64'(rd_repeat_o), 64'(e.rep));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle(2);
        rst_i = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] exp_addr);
        int n;
        wr_exp_q.push_back(exp_addr);
        wr_req_i = 1'b1;
        n = 0;
        do begin @(negedge clk_i); n++; end while (!wr_ack_o && n < 40);
        check_val("wr_latency", 64'(n), 64'd3);
        idle(1);
        wr_req_i = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] exp_addr, input logic exp_rep);
        int n;
        rd_exp_t e;
        e.addr = exp_addr;
        e.rep  = exp_rep;
        rd_exp_q.push_back(e);
        rd_req_i = 1'b1;
        n = 0;
        do begin @(negedge clk_i); n++; end while (!rd_ack_o && n < 40);
        check_val("rd_latency", 64'(n), 64'd3);
        idle(1);
        rd_req_i = 1'b0;
    endtask

    task automatic pulse_wr_done();
        wr_done_stb_i = 1'b1;
        idle(1);
        wr_done_stb_i = 1'b0;
    endtask

    task automatic pulse_rd_done();
        rd_done_stb_i = 1'b1;
        idle(1);
        rd_done_stb_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        a0 = START;
        a1 = START + PITCH;
        a2 = START + 2 * PITCH;

        // Reset values
        idle(3);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_val("rst_wr_ack", 64'(wr_ack_o), 64'd0);
        check_val("rst_rd_ack", 64'(rd_ack_o), 64'd0);
        check_val("rst_wr_addr", 64'(wr_addr_o), 64'(START));
        check_val("rst_rd_addr", 64'(rd_addr_o), 64'(START));
        check_val("rst_rd_repeat", 64'(rd_repeat_o), 64'd0);
`ifdef FRAME_BUF_SCHED_STATS_EN
        check_val("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
        check_val("rst_repeat_cnt", 64'(repeat_cnt_o), 64'd0);
`endif
        idle(1);

        // Basic write/read; aborted write re-uses its own slot
        do_write(a0);
        pulse_wr_done();
        do_read(a0, 1'b0);
        check_val("wr_addr_hold", 64'(wr_addr_o), 64'(a0));
        do_write(a1);
        do_write(a1);

        // Reader faster than writer: repeats, including re-request while reading
        do_reset();
        do_write(a0);
        pulse_wr_done();
        do_read(a0, 1'b0);
        pulse_rd_done();
        do_read(a0, 1'b1);
`ifdef FRAME_BUF_SCHED_STATS_EN
        check_val("repeat_cnt_1", 64'(repeat_cnt_o), 64'd1);
`endif
        do_read(a0, 1'b1);
        check_val("rd_addr_hold", 64'(rd_addr_o), 64'(a0));
`ifdef FRAME_BUF_SCHED_STATS_EN
        check_val("repeat_cnt_2", 64'(repeat_cnt_o), 64'd2);
`endif

        // Writer faster than reader: reader holds slot0, three frames complete
        do_reset();
        do_write(a0);
        pulse_wr_done();
        do_read(a0, 1'b0);
        do_write(a1);
        pulse_wr_done();
        do_write(a2);
        pulse_wr_done();
        do_write(a1);
        pulse_wr_done();
`ifdef FRAME_BUF_SCHED_STATS_EN
        check_val("drop_cnt_2", 64'(drop_cnt_o), 64'd2);
`endif
        do_read(a1, 1'b0);
        do_write(a0);

        // Both requests together: writer first, reader gets the frame completed in its ARB cycle
        do_reset();
        begin
            rd_exp_t e;
            e.addr = a0;
            e.rep  = 1'b0;
            wr_exp_q.push_back(a0);
            rd_exp_q.push_back(e);
        end
        wr_req_i = 1'b1;
        rd_req_i = 1'b1;
        n = 0;
        do begin @(negedge clk_i); n++; end while (!wr_ack_o && n < 40);
        check_val("both_wr_latency", 64'(n), 64'd3);
        check_val("both_rd_not_yet", 64'(rd_ack_o), 64'd0);
        idle(1);
        wr_req_i = 1'b0;
        @(negedge clk_i);
        check_val("both_rd_wait1", 64'(rd_ack_o), 64'd0);
        idle(1);
        wr_done_stb_i = 1'b1;
        @(negedge clk_i);
        check_val("both_rd_wait2", 64'(rd_ack_o), 64'd0);
        idle(1);
        wr_done_stb_i = 1'b0;
        @(negedge clk_i);
        check_val("both_rd_ack", 64'(rd_ack_o), 64'd1);
        idle(1);
        rd_req_i = 1'b0;

        // Read before any frame completes gets no grant
        do_reset();
        rd_req_i = 1'b1;
        seen = 1'b0;
        repeat (12) begin @(negedge clk_i); seen |= rd_ack_o; end
        check_val("rd_no_frame", 64'(seen), 64'd0);
        idle(1);
        rd_req_i = 1'b0;
        idle(3);

        // Reset during the grant cycle masks the ack and discards slot state
        do_write(a0);
        pulse_wr_done();
        wr_req_i = 1'b1;
        idle(2);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_val("rst_ack_mask", 64'(wr_ack_o), 64'd0);
        idle(1);
        rst_i = 1'b0;
        wr_req_i = 1'b0;
        @(negedge clk_i);
        check_val("rst_mid_wr_addr", 64'(wr_addr_o), 64'(START));
        idle(1);
        rd_req_i = 1'b1;
        seen = 1'b0;
        repeat (10) begin @(negedge clk_i); seen |= rd_ack_o; end
        check_val("rst_cleared_ready", 64'(seen), 64'd0);
        idle(1);
        rd_req_i = 1'b0;
        idle(3);
        do_write(a0);

        idle(4);
        check_val("wr_queue_empty", 64'(wr_exp_q.size()), 64'd0);
        check_val("rd_queue_empty", 64'(rd_exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
